// File: rtl/PCIE_PKG.sv
// Shared PCIe datapath constants.
// Beat width of the PIPE-side payload path.
package PCIE_PKG;
  localparam int PIPE_DATA_WIDTH = 64;
endpackage

// File: rtl/read_payload_handler_if.sv
// Descriptor, payload FIFO and AXI4 R bundle
// for the read payload handler.
interface read_payload_handler_if #(
  parameter int DATA_WIDTH = PCIE_PKG::PIPE_DATA_WIDTH,
  parameter int ID_WIDTH   = 4
);
  logic                  cpl_req_valid;
  logic                  cpl_req_ready;
  logic [ID_WIDTH-1:0]   cpl_req_id;
  logic [7:0]            cpl_req_len;
  logic                  cpl_req_err;
  logic                  payload_fifo_empty;
  logic                  payload_fifo_rden;
  logic [DATA_WIDTH-1:0] payload_fifo_rdata;
  logic                  rvalid;
  logic                  rready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  modport slave (
    input  cpl_req_valid, cpl_req_id,
    input  cpl_req_len, cpl_req_err,
    input  payload_fifo_empty,
    input  payload_fifo_rdata, rready,
    output cpl_req_ready, payload_fifo_rden,
    output rvalid, rid, rdata, rresp, rlast
  );

  modport master (
    output cpl_req_valid, cpl_req_id,
    output cpl_req_len, cpl_req_err,
    output payload_fifo_empty,
    output payload_fifo_rdata, rready,
    input  cpl_req_ready, payload_fifo_rden,
    input  rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/read_payload_handler.sv
// Turns a completion descriptor plus payload FIFO
// into an AXI4 R burst through a 2-entry skid buffer.
module read_payload_handler
  import PCIE_PKG::*;
#(
  parameter int DATA_WIDTH = PIPE_DATA_WIDTH,
  parameter int ID_WIDTH   = 4
) (
  input logic             clk,
  input logic             rst,
  read_payload_handler_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [7:0]            len_q;
  logic                  err_q;
  logic [8:0]            issued, delivered;
  logic [8:0]            total;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            occ, pending;
  logic                  req_hs, pop, push;
  logic                  gen, rden, more;
  logic [DATA_WIDTH-1:0] push_data;

  assign total   = {1'b0, len_q} + 9'd1;
  assign more    = issued < total;
  assign req_hs  = bus.cpl_req_valid & bus.cpl_req_ready;
  assign pop     = bus.rvalid & bus.rready;
  // A pop this cycle frees a slot, so credit it to keep full rate
  assign pending = occ + {1'b0, inflight} - {1'b0, pop};
  assign push    = inflight | gen;
  assign push_data = inflight ? bus.payload_fifo_rdata : '0;

  always_comb begin
    state_nxt = state;
    rden      = 1'b0;
    gen       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_hs) state_nxt = BURST;
      end
      BURST: begin
        if (more && pending < 2'd2) begin
          if (err_q) gen = 1'b1;
          else if (!bus.payload_fifo_empty && !rst) rden = 1'b1;
        end
        if (pop && bus.rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      id_q      <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      issued    <= '0;
      delivered <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occ       <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= rden;
      if (req_hs) begin
        id_q      <= bus.cpl_req_id;
        len_q     <= bus.cpl_req_len;
        err_q     <= bus.cpl_req_err;
        issued    <= '0;
        delivered <= '0;
      end else begin
        if (rden || gen) issued <= issued + 9'd1;
        if (pop) delivered <= delivered + 9'd1;
      end
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr] <= push_data;
  end

  assign bus.cpl_req_ready     = (state == IDLE) & ~rst;
  assign bus.payload_fifo_rden = rden;
  assign bus.rvalid = (occ != 2'd0) & ~rst;
  assign bus.rdata  = bus.rvalid ? buf_q[rd_ptr] : '0;
  assign bus.rid    = bus.rvalid ? id_q : '0;
  assign bus.rresp  = (bus.rvalid & err_q) ? 2'b10 : 2'b00;
  assign bus.rlast  = bus.rvalid & (delivered == {1'b0, len_q});
endmodule

// File: tb/tb_read_payload_handler.sv
// Scoreboard bench for read_payload_handler:
// FIFO model, R-channel monitor, directed bursts.
module tb_read_payload_handler;
  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  read_payload_handler_if #(.DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

  read_payload_handler #(.DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // payload FIFO model
  logic [31:0] fmem [64];
  int          wr_i = 0;
  int          rd_i = 0;
  int          uf   = 0;
  logic [31:0] fdata = '0;
  assign bus.payload_fifo_empty = (wr_i == rd_i);
  assign bus.payload_fifo_rdata = fdata;

  always @(posedge clk) begin
    if (bus.payload_fifo_rden) begin
      if (wr_i == rd_i) uf <= uf + 1;
      else begin
        fdata <= fmem[rd_i % 64];
        rd_i  <= rd_i + 1;
      end
    end
  end

  // rready: level or toggling
  logic rr = 1'b1;
  logic tog_en = 1'b0;
  logic tog = 1'b1;
  always @(posedge clk) tog <= ~tog;
  assign bus.rready = tog_en ? tog : rr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  beat_t       exp_q [$];
  int          hs_cyc [$];
  int          hs_cnt   = 0;
  int          rden_cnt = 0;
  logic        mon_out  = 1'b0;
  int          base_r   = 0;
  int          base_h   = 0;
  logic        stalled  = 1'b0;
  logic        rdy_chk  = 1'b0;
  logic [63:0] prev     = '0;

  always @(negedge clk) begin
    beat_t e;
    logic [63:0] cur;
    cur = {24'd0, bus.rvalid, bus.rdata,
           bus.rid, bus.rresp, bus.rlast};
    if (rst) begin
      stalled = 1'b0;
      rdy_chk = 1'b0;
    end else begin
      if (rdy_chk) check("ready_after_last", bus.cpl_req_ready, 1);
      rdy_chk = 1'b0;
      if (stalled) check("stall_stable", cur, prev);
      if (!bus.rvalid)
        check("idle_zero", {bus.rdata, bus.rid,
                            bus.rresp, bus.rlast}, 0);
      if (bus.payload_fifo_rden) rden_cnt++;
      if (bus.rvalid && bus.rready) begin
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("rid", bus.rid, e.id);
          check("rdata", bus.rdata, e.data);
          check("rresp", bus.rresp, e.resp);
          check("rlast", bus.rlast, e.last);
        end
        hs_cnt++;
        hs_cyc.push_back(cyc);
        if (bus.rlast) rdy_chk = 1'b1;
      end
      if (mon_out)
        check("outstanding",
              64'((rden_cnt - base_r) - (hs_cnt - base_h) <= 2), 1);
      stalled = bus.rvalid && !bus.rready;
      prev = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fmem[wr_i % 64] = base + 32'(i);
      wr_i++;
    end
  endtask

  task automatic send(input logic [3:0] id, input logic [7:0] len,
                      input logic err, input logic [31:0] base);
    beat_t b;
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.data = err ? 32'd0 : base + 32'(i);
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
    bus.cpl_req_valid = 1'b1;
    bus.cpl_req_id    = id;
    bus.cpl_req_len   = len;
    bus.cpl_req_err   = err;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cpl_req_ready && n < 50);
    check("req_accept", bus.cpl_req_ready, 1);
    step();
    bus.cpl_req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rvalid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n < 300), 1);
    step();
  endtask

  int b0;
  int n;

  initial begin
    bus.cpl_req_valid = 1'b0;
    bus.cpl_req_id    = '0;
    bus.cpl_req_len   = '0;
    bus.cpl_req_err   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.cpl_req_ready, 0);
    check("rst_rvalid", bus.rvalid, 0);
    check("rst_rden", bus.payload_fifo_rden, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", bus.cpl_req_ready, 1);
    check("post_rst_rvalid", bus.rvalid, 0);
    step();

    // len=3, preloaded A..D, full rate
    load(32'hA, 4);
    b0 = hs_cyc.size();
    base_r = rden_cnt;
    send(4'd2, 8'd3, 1'b0, 32'hA);
    wait_done("len3_done");
    check("len3_consecutive", 64'(hs_cyc[b0 + 3] - hs_cyc[b0]), 3);
    check("len3_rden_count", 64'(rden_cnt - base_r), 4);

    // len=0, id=5
    load(32'h55, 1);
    send(4'd5, 8'd0, 1'b0, 32'h55);
    wait_done("len0_done");

    // len=7 with rready toggling
    load(32'h700, 8);
    base_r = rden_cnt;
    base_h = hs_cnt;
    mon_out = 1'b1;
    tog_en = 1'b1;
    send(4'd7, 8'd7, 1'b0, 32'h700);
    wait_done("toggle_done");
    tog_en = 1'b0;
    mon_out = 1'b0;
    check("toggle_rden_count", 64'(rden_cnt - base_r), 8);

    // error burst, FIFO empty
    base_r = rden_cnt;
    send(4'd9, 8'd2, 1'b1, 32'h0);
    wait_done("err_done");
    check("err_no_rden", 64'(rden_cnt - base_r), 0);

    // FIFO runs dry after 2 beats, refills later
    load(32'h400, 2);
    b0 = hs_cnt;
    send(4'd4, 8'd4, 1'b0, 32'h400);
    n = 0;
    while (hs_cnt < b0 + 2 && n < 50) begin
      step();
      n++;
    end
    check("dry_first_two", 64'(n < 50), 1);
    repeat (2) @(negedge clk);
    check("dry_gap_rvalid", bus.rvalid, 0);
    check("dry_gap_rden", bus.payload_fifo_rden, 0);
    step();
    repeat (2) step();
    load(32'h402, 3);
    wait_done("dry_done");

    // reset in the middle of a len=7 burst
    load(32'h800, 8);
    b0 = hs_cnt;
    send(4'd3, 8'd7, 1'b0, 32'h800);
    n = 0;
    while (hs_cnt < b0 + 2 && n < 50) begin
      step();
      n++;
    end
    check("mid_beat2", 64'(n < 50), 1);
    rst = 1'b1;
    exp_q.delete();
    wr_i = rd_i;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid", bus.rvalid, 0);
    check("mid_rst_rden", bus.payload_fifo_rden, 0);
    check("mid_rst_ready", bus.cpl_req_ready, 1);
    step();
    load(32'h900, 1);
    send(4'd6, 8'd0, 1'b0, 32'h900);
    wait_done("after_rst_done");

    check("fifo_underflow", 64'(uf), 0);
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
